// File: rtl/ff_pkg.sv
// Shared flip-flop mode encodings for the configurable flip-flop bank.
package ff_pkg;
  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_T  = 2'b10,
    MODE_D  = 2'b11
  } ff_mode_e;
endpackage

// File: rtl/dff_cell.sv
// Single D flip-flop with synchronous active-high reset and complement output.
module dff_cell (
  input  logic d,
  input  logic clk,
  input  logic reset,
  output logic q,
  output logic qb
);
  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= d;
  end

  assign q  = q_q;
  assign qb = ~q_q;
endmodule

// File: rtl/d_to_sr_bank.sv
// Bank of D flops emulating SR/JK/T/D behaviour per cycle, with sticky
// illegal-SR tracking and a saturating illegal-cycle counter.
module d_to_sr_bank
  import ff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err_bit,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] ill_vec;
  logic [WIDTH-1:0] err_bit_d, err_bit_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

  always_comb begin
    d = q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (ff_mode_e'(mode))
          MODE_SR: d[i] = a[i] ? (b[i] ? q[i] : 1'b1) : (b[i] ? 1'b0 : q[i]);
          MODE_JK: d[i] = a[i] ? (b[i] ? ~q[i] : 1'b1) : (b[i] ? 1'b0 : q[i]);
          MODE_T:  d[i] = a[i] ? ~q[i] : q[i];
          MODE_D:  d[i] = a[i];
          default: d[i] = q[i];
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_cell
      dff_cell u_cell (
        .d     (d[g]),
        .clk   (clk),
        .reset (reset),
        .q     (q[g]),
        .qb    (qb[g])
      );
    end
  endgenerate

  // Clear has priority over a coincident illegal event.
  always_comb begin
    ill_vec   = (en && (mode == MODE_SR)) ? (a & b) : '0;
    err_bit_d = err_bit_q | ill_vec;
    err_cnt_d = err_cnt_q;
    if ((|ill_vec) && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
    if (clr_err) begin
      err_bit_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_bit_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_bit_q <= err_bit_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_bit  = err_bit_q;
  assign err_flag = |err_bit_q;
  assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_d_to_sr_bank.sv
// Directed and randomized checks of d_to_sr_bank (default and CNT_W=2 instances).
module tb_d_to_sr_bank;
  logic       clk = 1'b0;
  logic       reset, en, clr_err;
  logic [1:0] mode;
  logic [3:0] a, b;
  logic [3:0] q, qb, err_bit, q2, qb2, err_bit2;
  logic       err_flag, err_flag2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  d_to_sr_bank #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
    .clr_err(clr_err), .q(q), .qb(qb), .err_bit(err_bit),
    .err_flag(err_flag), .err_cnt(err_cnt)
  );

  d_to_sr_bank #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
    .clr_err(clr_err), .q(q2), .qb(qb2), .err_bit(err_bit2),
    .err_flag(err_flag2), .err_cnt(err_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mode = 2'b11; a = 4'hf; b = 4'hf; clr_err = 1'b0;
    step(); step();
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL reset_q got=%h exp=0", q); end
    n_cmp++; if (qb !== 4'hf) begin n_bad++; $display("FAIL reset_qb got=%h exp=f", qb); end
    n_cmp++; if (err_bit !== 4'h0 || err_flag !== 1'b0 || err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_err got bit=%h flag=%b cnt=%0d exp 0/0/0", err_bit, err_flag, err_cnt);
    end
    n_cmp++; if (q2 !== 4'h0 || err_cnt2 !== 2'd0) begin
      n_bad++; $display("FAIL reset_dut2 got q=%h cnt=%0d exp 0/0", q2, err_cnt2);
    end
  endtask

  task automatic test_sr();
    reset = 1'b0; mode = 2'b00; a = 4'b0101; b = 4'b1010; en = 1'b1;
    step();
    n_cmp++; if (q !== 4'b0101 || qb !== 4'b1010) begin
      n_bad++; $display("FAIL sr_setreset got q=%b qb=%b exp 0101/1010", q, qb);
    end
    a = 4'b0000; b = 4'b0000;
    step();
    n_cmp++; if (q !== 4'b0101) begin n_bad++; $display("FAIL sr_hold got=%b exp=0101", q); end
  endtask

  task automatic test_illegal();
    a = 4'b1001; b = 4'b1001;
    step();
    n_cmp++; if (err_cnt !== 8'd1 || err_bit !== 4'b1001) begin
      n_bad++; $display("FAIL illegal_first got cnt=%0d bit=%b exp 1/1001", err_cnt, err_bit);
    end
    step(); step();
    n_cmp++; if (q !== 4'b0101) begin n_bad++; $display("FAIL illegal_q got=%b exp=0101", q); end
    n_cmp++; if (err_bit !== 4'b1001 || err_flag !== 1'b1) begin
      n_bad++; $display("FAIL illegal_err got bit=%b flag=%b exp 1001/1", err_bit, err_flag);
    end
    n_cmp++; if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL illegal_cnt got=%0d exp=3", err_cnt); end
    a = 4'b0000; b = 4'b0000;
    step();
    n_cmp++; if (err_bit !== 4'b1001 || err_cnt !== 8'd3) begin
      n_bad++; $display("FAIL illegal_sticky got bit=%b cnt=%0d exp 1001/3", err_bit, err_cnt);
    end
  endtask

  task automatic test_jk_t();
    logic [3:0] exp;
    mode = 2'b00; a = 4'b0000; b = 4'b1111; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++; if (q !== 4'h0 || err_flag !== 1'b0) begin
      n_bad++; $display("FAIL jk_prep got q=%b flag=%b exp 0000/0", q, err_flag);
    end
    mode = 2'b01; a = 4'b1111; b = 4'b1111;
    exp = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = ~exp;
      n_cmp++; if (q !== exp) begin n_bad++; $display("FAIL jk_toggle%0d got=%b exp=%b", i, q, exp); end
    end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL jk_noerr got cnt=%0d exp=0", err_cnt); end
    mode = 2'b10; a = 4'b0001; b = 4'b0000;
    step();
    n_cmp++; if (q !== 4'b1110) begin n_bad++; $display("FAIL t_toggle got=%b exp=1110", q); end
    mode = 2'b01; a = 4'b0011; b = 4'b1100;
    step();
    n_cmp++; if (q !== 4'b0011) begin n_bad++; $display("FAIL jk_setreset got=%b exp=0011", q); end
    mode = 2'b10; a = 4'b0000;
    step();
    n_cmp++; if (q !== 4'b0011) begin n_bad++; $display("FAIL t_hold got=%b exp=0011", q); end
  endtask

  task automatic test_sat();
    mode = 2'b00; a = 4'b0100; b = 4'b0100;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (err_cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_cnt2 got=%0d exp=3", err_cnt2); end
    n_cmp++; if (err_cnt !== 8'd5) begin n_bad++; $display("FAIL sat_cnt8 got=%0d exp=5", err_cnt); end
    n_cmp++; if (q !== 4'b0011) begin n_bad++; $display("FAIL sat_q got=%b exp=0011", q); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++; if (err_cnt2 !== 2'd0 || err_bit2 !== 4'h0 || err_flag2 !== 1'b0) begin
      n_bad++; $display("FAIL clr_wins2 got cnt=%0d bit=%b flag=%b exp 0/0000/0", err_cnt2, err_bit2, err_flag2);
    end
    n_cmp++; if (err_cnt !== 8'd0 || err_bit !== 4'h0) begin
      n_bad++; $display("FAIL clr_wins got cnt=%0d bit=%b exp 0/0000", err_cnt, err_bit);
    end
  endtask

  task automatic test_enable_reset();
    en = 1'b0; mode = 2'b11; a = 4'b1111; b = 4'b1111;
    step();
    n_cmp++; if (q !== 4'b0011) begin n_bad++; $display("FAIL en_hold got=%b exp=0011", q); end
    mode = 2'b00;
    step();
    n_cmp++; if (err_flag !== 1'b0 || err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL en_noerr got flag=%b cnt=%0d exp 0/0", err_flag, err_cnt);
    end
    en = 1'b1; mode = 2'b11; reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (q !== 4'h0 || qb !== 4'hf) begin
      n_bad++; $display("FAIL midreset got q=%b qb=%b exp 0000/1111", q, qb);
    end
    a = 4'b1010;
    step();
    n_cmp++; if (q !== 4'b1010) begin n_bad++; $display("FAIL resume got=%b exp=1010", q); end
  endtask

  task automatic test_random();
    logic [3:0] mq, merr, ill;
    logic [7:0] mc;
    logic [1:0] mc2;
    reset = 1'b1; clr_err = 1'b0;
    step();
    mq = 0; merr = 0; mc = 0; mc2 = 0;
    for (int c = 0; c < 2000; c++) begin
      reset   = ($urandom_range(0, 31) == 0);
      clr_err = ($urandom_range(0, 15) == 0);
      en      = ($urandom_range(0, 3) != 0);
      mode    = 2'($urandom_range(0, 3));
      a       = 4'($urandom_range(0, 15));
      b       = 4'($urandom_range(0, 15));
      if (reset) begin
        mq = 0; merr = 0; mc = 0; mc2 = 0;
      end else begin
        ill = (en && mode == 2'b00) ? (a & b) : 4'h0;
        if (en) begin
          for (int i = 0; i < 4; i++) begin
            case (mode)
              2'b00: if (a[i] != b[i]) mq[i] = a[i];
              2'b01: if (a[i] && b[i]) mq[i] = ~mq[i]; else if (a[i] != b[i]) mq[i] = a[i];
              2'b10: if (a[i]) mq[i] = ~mq[i];
              default: mq[i] = a[i];
            endcase
          end
        end
        if (clr_err) begin
          merr = 0; mc = 0; mc2 = 0;
        end else begin
          merr = merr | ill;
          if (ill != 0) begin
            if (mc != 8'd255) mc = mc + 8'd1;
            if (mc2 != 2'd3) mc2 = mc2 + 2'd1;
          end
        end
      end
      step();
      n_cmp++; if (q !== mq || qb !== ~mq) begin
        n_bad++; $display("FAIL rand_q c=%0d got q=%b qb=%b exp q=%b", c, q, qb, mq);
      end
      n_cmp++; if (err_bit !== merr || err_flag !== (|merr) || err_cnt !== mc || err_cnt2 !== mc2) begin
        n_bad++; $display("FAIL rand_err c=%0d got bit=%b flag=%b cnt=%0d cnt2=%0d exp %b/%b/%0d/%0d",
                          c, err_bit, err_flag, err_cnt, err_cnt2, merr, |merr, mc, mc2);
      end
    end
    reset = 1'b0; clr_err = 1'b0;
  endtask

  // qb must be the complement of q on every cycle once q is defined.
  always @(negedge clk) begin
    if (!$isunknown(q) && qb !== ~q) begin
      n_cmp++; n_bad++;
      $display("FAIL qb_complement got q=%b qb=%b", q, qb);
    end
  end

  initial begin
    test_reset();
    test_sr();
    test_illegal();
    test_jk_t();
    test_sat();
    test_enable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
